// File: rtl/input_debounce_if.sv
// Pin-side bundle for input_debounce: raw asynchronous levels in, clean levels and strobes out.
// The master drives the raw pins. The slave is the debouncer.
interface input_debounce_if #(
   parameter int N = 11
) ();
   logic [N-1:0] raw_in;
   logic [N-1:0] level;
   logic [N-1:0] rise;
   logic [N-1:0] fall;
   logic         changed;

   modport master (
      output raw_in,
      input  level,
      input  rise,
      input  fall,
      input  changed
   );

   modport slave (
      input  raw_in,
      output level,
      output rise,
      output fall,
      output changed
   );
endinterface

// File: rtl/input_debounce.sv
// Per-channel synchroniser + debouncer with inversion mask; new level and strobes appear SYNC_STAGES+DEBOUNCE_CYCLES-1 edges after the first sampling edge.
// No backpressure: outputs are free-running registered levels and one-cycle strobes.
module input_debounce #(
   parameter int          N               = 11,
   parameter int          SYNC_STAGES     = 2,
   parameter int          DEBOUNCE_CYCLES = 500000,
   parameter logic [N-1:0] INVERT         = '0
) (
   input logic             clk,
   input logic             rst,
   input_debounce_if.slave bus
);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   generate
      if (SYNC_STAGES < 2) begin : g_bad_sync
         $error("input_debounce: SYNC_STAGES must be at least 2");
      end
      if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
         $error("input_debounce: DEBOUNCE_CYCLES must be at least 1");
      end
   endgenerate

   logic [N-1:0]     w_norm;
   logic [N-1:0]     w_sync;
   logic [N-1:0]     r_sync [SYNC_STAGES];
   logic [CNT_W-1:0] r_cnt [N];
   logic [CNT_W-1:0] w_cnt_nxt [N];
   logic [N-1:0]     r_level;
   logic [N-1:0]     r_rise;
   logic [N-1:0]     r_fall;
   logic             r_changed;
   logic [N-1:0]     w_level_nxt;
   logic [N-1:0]     w_rise_nxt;
   logic [N-1:0]     w_fall_nxt;

   assign w_norm = bus.raw_in ^ INVERT;
   assign w_sync = r_sync[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            r_sync[s] <= '0;
         end
      end else begin
         r_sync[0] <= w_norm;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            r_sync[s] <= r_sync[s-1];
         end
      end
   end

   // Any cycle where sync agrees with level clears the count, so bounces restart it.
   always_comb begin
      w_level_nxt = r_level;
      w_rise_nxt  = '0;
      w_fall_nxt  = '0;
      for (int i = 0; i < N; i++) begin
         w_cnt_nxt[i] = '0;
         if (w_sync[i] != r_level[i]) begin
            if (r_cnt[i] == CNT_MAX) begin
               w_level_nxt[i] = w_sync[i];
               w_rise_nxt[i]  = w_sync[i];
               w_fall_nxt[i]  = ~w_sync[i];
            end else begin
               w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            r_cnt[i] <= '0;
         end
         r_level   <= '0;
         r_rise    <= '0;
         r_fall    <= '0;
         r_changed <= 1'b0;
      end else begin
         for (int i = 0; i < N; i++) begin
            r_cnt[i] <= w_cnt_nxt[i];
         end
         r_level   <= w_level_nxt;
         r_rise    <= w_rise_nxt;
         r_fall    <= w_fall_nxt;
         r_changed <= |(w_rise_nxt | w_fall_nxt);
      end
   end

   assign bus.level   = r_level;
   assign bus.rise    = r_rise;
   assign bus.fall    = r_fall;
   assign bus.changed = r_changed;
endmodule

// File: tb/tb_input_debounce.sv
// Directed bench for input_debounce with N=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, INVERT=4'b1000.
module tb_input_debounce;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

   input_debounce_if #(.N(4)) bus ();

   input_debounce #(
      .N(4),
      .SYNC_STAGES(2),
      .DEBOUNCE_CYCLES(4),
      .INVERT(4'b1000)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [3:0] raw;
      logic [3:0] level;
      logic [3:0] rise;
      logic [3:0] fall;
      logic       changed;
      string      name;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input int n, input logic r, input logic [3:0] raw,
                               input logic [3:0] lvl, input logic [3:0] ri,
                               input logic [3:0] fa, input logic ch, input string name);
      vec_t v;
      v.rst = r; v.raw = raw; v.level = lvl; v.rise = ri; v.fall = fa;
      v.changed = ch; v.name = name;
      for (int k = 0; k < n; k++) vecs.push_back(v);
   endfunction

   // Apply inputs, let one edge sample them, then compare on the falling edge.
   task automatic step(input logic r, input logic [3:0] raw,
                       input logic [3:0] lvl, input logic [3:0] ri,
                       input logic [3:0] fa, input logic ch, input string name);
      logic [12:0] act;
      logic [12:0] exp;
      rst = r;
      bus.raw_in = raw;
      @(posedge clk);
      @(negedge clk);
      act = {bus.level, bus.rise, bus.fall, bus.changed};
      exp = {lvl, ri, fa, ch};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got lvl=%b rise=%b fall=%b chg=%b, want lvl=%b rise=%b fall=%b chg=%b",
                  name, $time, bus.level, bus.rise, bus.fall, bus.changed, lvl, ri, fa, ch);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.raw_in = 4'b1000;

      // Reset, then idle with ch3 released (normalises to 0).
      add(3, 1, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 0, "reset");
      add(6, 0, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 0, "idle_after_reset");
      // Clean rise on ch0: E0 is the first vector below, commit at E0+5.
      add(5, 0, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 0, "rise0_wait");
      add(1, 0, 4'b1001, 4'b0001, 4'b0001, 4'b0000, 1, "rise0_commit");
      add(3, 0, 4'b1001, 4'b0001, 4'b0000, 4'b0000, 0, "rise0_hold");
      // Glitch on ch1: three cycles high only.
      add(3, 0, 4'b1011, 4'b0001, 4'b0000, 4'b0000, 0, "glitch1_high");
      add(7, 0, 4'b1001, 4'b0001, 4'b0000, 4'b0000, 0, "glitch1_after");
      // Drop ch0, then raise ch1:0 together.
      add(5, 0, 4'b1000, 4'b0001, 4'b0000, 4'b0000, 0, "fall0_wait");
      add(1, 0, 4'b1000, 4'b0000, 4'b0000, 4'b0001, 1, "fall0_commit");
      add(2, 0, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 0, "fall0_hold");
      add(5, 0, 4'b1011, 4'b0000, 4'b0000, 4'b0000, 0, "simul_wait");
      add(1, 0, 4'b1011, 4'b0011, 4'b0011, 4'b0000, 1, "simul_commit");
      add(2, 0, 4'b1011, 4'b0011, 4'b0000, 4'b0000, 0, "simul_hold");

      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].raw, vecs[i].level, vecs[i].rise,
              vecs[i].fall, vecs[i].changed, vecs[i].name);
      end

      // Bounce on ch2: 1,0,1,0 then stable 1 first sampled at k=4, rise at k=9.
      for (int k = 0; k < 14; k++) begin
         logic [3:0] raw;
         raw = (k == 1 || k == 3) ? 4'b1011 : 4'b1111;
         step(0, raw, (k >= 9) ? 4'b0111 : 4'b0011, (k == 9) ? 4'b0100 : 4'b0000,
              4'b0000, k == 9, "bounce2");
      end

      // Release all normalised inputs so only ch3 moves in the next sequence.
      for (int k = 0; k < 8; k++) begin
         step(0, 4'b1000, (k >= 5) ? 4'b0000 : 4'b0111, 4'b0000,
              (k == 5) ? 4'b0111 : 4'b0000, k == 5, "fall_all");
      end

      // Press ch3 (active low), reset at E0+3, release at E0+4: rise at E0+9.
      for (int k = 0; k < 12; k++) begin
         step(k == 3, 4'b0000, (k >= 9) ? 4'b1000 : 4'b0000,
              (k == 9) ? 4'b1000 : 4'b0000, 4'b0000, k == 9, "press3_midreset");
      end

      // Release ch3: fall after 5 edges.
      for (int k = 0; k < 8; k++) begin
         step(0, 4'b1000, (k >= 5) ? 4'b0000 : 4'b1000, 4'b0000,
              (k == 5) ? 4'b1000 : 4'b0000, k == 5, "release3");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
